// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared bus sizing, arbiter state type and bus source indices
package bus_pkg;

  localparam int N_SRC = 32;
  localparam int SEL_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } arb_state_e;

  // Source indices shared with the 32:1 bus mux and the datapath top
  localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
  localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
  localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
  localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
  localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
  localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
  localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
  localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
  localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
  localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
  localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
  localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
  localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
  localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
  localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
  localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
  localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
  localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
  localparam logic [SEL_W-1:0] SRC_ZHI    = 5'd18;
  localparam logic [SEL_W-1:0] SRC_ZLO    = 5'd19;
  localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
  localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
  localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [SEL_W-1:0] SRC_C      = 5'd23;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin find-first starting at rr_ptr with wrap-around
module rr_priority_pick
  import bus_pkg::*;
#(
  parameter int N = N_SRC,
  parameter int W = SEL_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr_ptr,
  output logic         any,
  output logic [W-1:0] win_idx
);

  localparam logic [W:0] N_L = (W+1)'(N);

  logic [N-1:0] rot;
  logic [W-1:0] first;
  logic [W:0]   sum;

  // rot[i] is the source i places after rr_ptr, so rot[0] has top priority
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[(i + int'(rr_ptr)) % N];
    end
  end

  always_comb begin
    first = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) first = W'(i);
    end
  end

  assign any     = |req;
  assign sum     = {1'b0, first} + {1'b0, rr_ptr};
  assign win_idx = (sum >= N_L) ? W'(sum - N_L) : sum[W-1:0];

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - round-robin bus arbiter with turnaround cycle and bounded tenure
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] grant,
  output logic [SEL_W-1:0] select,
  output logic             bus_valid,
  output logic             preempt
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state, state_d;
  logic [SEL_W-1:0]  rr_ptr, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
  logic [N_SRC-1:0]  grant_d;
  logic [SEL_W-1:0]  select_d;
  logic              bus_valid_d, preempt_d;
  logic              any_req;
  logic [SEL_W-1:0]  win_idx;
  logic              contended;

  rr_priority_pick #(.N(N_SRC), .W(SEL_W)) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .any     (any_req),
    .win_idx (win_idx)
  );

  assign contended = |(req & ~grant);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      grant     <= '0;
      select    <= '0;
      bus_valid <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      hold_cnt  <= hold_cnt_d;
      grant     <= grant_d;
      select    <= select_d;
      bus_valid <= bus_valid_d;
      preempt   <= preempt_d;
    end
  end

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    hold_cnt_d  = hold_cnt;
    grant_d     = grant;
    select_d    = select;
    bus_valid_d = bus_valid;
    preempt_d   = 1'b0;
    case (state)
      IDLE, TURN: begin
        if (any_req) begin
          state_d     = OWN;
          grant_d     = N_SRC'(1) << win_idx;
          select_d    = win_idx;
          bus_valid_d = 1'b1;
          hold_cnt_d  = '0;
          rr_ptr_d    = (win_idx == SEL_W'(N_SRC - 1)) ? '0 : win_idx + SEL_W'(1);
        end else begin
          state_d     = IDLE;
          grant_d     = '0;
          bus_valid_d = 1'b0;
        end
      end
      OWN: begin
        // A release on the expiry edge is a normal release, so it is tested first
        if (!req[select]) begin
          state_d     = TURN;
          grant_d     = '0;
          bus_valid_d = 1'b0;
        end else if (hold_cnt == HOLD_LAST && contended) begin
          state_d     = TURN;
          grant_d     = '0;
          bus_valid_d = 1'b0;
          preempt_d   = 1'b1;
        end else if (hold_cnt != HOLD_LAST) begin
          hold_cnt_d  = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        grant_d     = '0;
        bus_valid_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - directed self-checking bench for bus_arbiter_rr
module tb_bus_arbiter_rr;
  import bus_pkg::*;

  logic             clock;
  logic             clear;
  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] grant;
  logic [SEL_W-1:0] select;
  logic             bus_valid;
  logic             preempt;

  int errors = 0;
  int checks = 0;

  bus_arbiter_rr #(.MAX_HOLD(4)) dut (
    .clock     (clock),
    .clear     (clear),
    .req       (req),
    .grant     (grant),
    .select    (select),
    .bus_valid (bus_valid),
    .preempt   (preempt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Full owner snapshot: grant, select, bus_valid, preempt
  task automatic expect_state(input string tag, input logic [31:0] g, input logic [4:0] s,
                              input logic v, input logic p);
    check({tag, ".grant"}, grant, g);
    check({tag, ".select"}, 32'(select), 32'(s));
    check({tag, ".valid"}, 32'(bus_valid), 32'(v));
    check({tag, ".preempt"}, 32'(preempt), 32'(p));
  endtask

  task automatic do_reset();
    clear = 1'b0;
    tick();
    tick();
    clear = 1'b1;
  endtask

  initial begin
    // 1: reset with PC requesting
    clear = 1'b0;
    req   = 32'h0010_0000;
    tick();
    tick();
    expect_state("t1_rst", 32'h0, 5'd0, 1'b0, 1'b0);
    clear = 1'b1;
    tick();
    expect_state("t1_own", 32'h0010_0000, SRC_PC, 1'b1, 1'b0);
    req = 32'h0;
    tick();
    expect_state("t1_turn", 32'h0, 5'd20, 1'b0, 1'b0);
    tick();
    expect_state("t1_idle", 32'h0, 5'd20, 1'b0, 1'b0);

    // 2: sources 3 and 7 alternate under preemption
    do_reset();
    req = 32'h0000_0088;
    tick();
    for (int k = 0; k < 4; k++) begin
      expect_state("t2_own3", 32'h8, 5'd3, 1'b1, 1'b0);
      tick();
    end
    expect_state("t2_pre3", 32'h0, 5'd3, 1'b0, 1'b1);
    tick();
    for (int k = 0; k < 4; k++) begin
      expect_state("t2_own7", 32'h80, 5'd7, 1'b1, 1'b0);
      tick();
    end
    expect_state("t2_pre7", 32'h0, 5'd7, 1'b0, 1'b1);
    tick();
    expect_state("t2_back3", 32'h8, 5'd3, 1'b1, 1'b0);
    req = 32'h0;
    tick();
    tick();

    // 3: wrap from 31 to 0 (rr_ptr 4 -> src 30 wins -> rr_ptr 31)
    req = 32'h4000_0000;
    tick();
    expect_state("t3_own30", 32'h4000_0000, 5'd30, 1'b1, 1'b0);
    req = 32'h8000_0001;
    tick();
    expect_state("t3_turn", 32'h0, 5'd30, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      expect_state("t3_own31", 32'h8000_0000, 5'd31, 1'b1, 1'b0);
      tick();
    end
    expect_state("t3_pre31", 32'h0, 5'd31, 1'b0, 1'b1);
    tick();
    expect_state("t3_own0", 32'h1, 5'd0, 1'b1, 1'b0);
    req = 32'h0;
    tick();
    tick();

    // 4: sole requester keeps the bus indefinitely
    req = 32'h0000_0020;
    tick();
    for (int k = 0; k < 20; k++) begin
      expect_state("t4_own5", 32'h20, 5'd5, 1'b1, 1'b0);
      tick();
    end
    req = 32'h0;
    tick();
    expect_state("t4_turn", 32'h0, 5'd5, 1'b0, 1'b0);
    tick();
    expect_state("t4_idle", 32'h0, 5'd5, 1'b0, 1'b0);

    // 5: release on the expiry edge is not a preemption (rr_ptr 6 -> src 2)
    req = 32'h0000_0004;
    tick();
    expect_state("t5_own2a", 32'h4, 5'd2, 1'b1, 1'b0);
    req = 32'h0000_0204;
    tick();
    tick();
    tick();
    expect_state("t5_own2d", 32'h4, 5'd2, 1'b1, 1'b0);
    req = 32'h0000_0200;
    tick();
    expect_state("t5_turn", 32'h0, 5'd2, 1'b0, 1'b0);
    tick();
    expect_state("t5_own9", 32'h200, 5'd9, 1'b1, 1'b0);

    // 6: asynchronous clear mid-tenure, then restart from rr_ptr 0
    req = 32'h0000_1000;
    tick();
    tick();
    expect_state("t6_own12", 32'h1000, 5'd12, 1'b1, 1'b0);
    #2 clear = 1'b0;
    #1;
    expect_state("t6_async", 32'h0, 5'd0, 1'b0, 1'b0);
    req = 32'h0000_3000;
    tick();
    tick();
    clear = 1'b1;
    tick();
    expect_state("t6_restart", 32'h1000, 5'd12, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
